// File: rtl/reg_file_sb_pkg.sv
// Shared constants and types for the register file, writeback and decode.
package reg_file_sb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int CNT_W    = 2;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] reg_data_t;
    typedef logic [CNT_W-1:0]  sb_cnt_t;

    localparam sb_cnt_t CNT_MAX = sb_cnt_t'(2 ** CNT_W - 1);

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register pending-write counters: issue increments, writeback retires.
// Produces busy/retire_last vectors, sb_full for the issuing index and sticky sb_err.
module reg_scoreboard
    import reg_file_sb_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_en_i,
    input  reg_idx_t            issue_reg_i,
    input  logic                retire_en_i,
    input  reg_idx_t            retire_reg_i,
    output logic [NUM_REGS-1:0] busy_o,
    output logic [NUM_REGS-1:0] retire_last_o,
    output logic                sb_full_o,
    output logic                sb_err_o
);

    sb_cnt_t cnt_q [NUM_REGS];
    sb_cnt_t cnt_d [NUM_REGS];
    logic    err_q, err_d;

    assign sb_full_o = (cnt_q[issue_reg_i] == CNT_MAX);
    assign sb_err_o  = err_q;

    always_comb begin
        logic inc, dec;
        inc = 1'b0;
        dec = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            inc = issue_en_i && (issue_reg_i == reg_idx_t'(r)) && !sb_full_o;
            dec = retire_en_i && (retire_reg_i == reg_idx_t'(r)) && (cnt_q[r] != '0);
            cnt_d[r] = cnt_q[r];
            if (inc && !dec)
                cnt_d[r] = cnt_q[r] + sb_cnt_t'(1);
            else if (dec && !inc)
                cnt_d[r] = cnt_q[r] - sb_cnt_t'(1);
            busy_o[r]        = (cnt_q[r] != '0);
            retire_last_o[r] = retire_en_i && (retire_reg_i == reg_idx_t'(r))
                               && (cnt_q[r] == sb_cnt_t'(1));
        end
        err_d = err_q
              | (issue_en_i && sb_full_o)
              | (retire_en_i && (cnt_q[retire_reg_i] == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Architectural register file with two combinational read ports and a RAW scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle writeback data and drop Busy on the last retire.
module reg_file_sb
    import reg_file_sb_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  reg_idx_t  WriteRegIn,
    input  reg_data_t WriteDataIn,
    input  logic      write_en,
    input  reg_idx_t  ReadReg1,
    input  reg_idx_t  ReadReg2,
    output reg_data_t ReadData1,
    output reg_data_t ReadData2,
    output logic      Busy1,
    output logic      Busy2,
    input  logic      issue_en,
    input  reg_idx_t  IssueReg,
    output logic      sb_full,
    output logic      sb_err
);

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    reg_data_t            regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]  busy;
    logic [NUM_REGS-1:0]  retire_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
        end else if (write_en) begin
            regs_q[WriteRegIn] <= WriteDataIn;
        end
    end

    reg_scoreboard u_sb (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_en_i    (issue_en),
        .issue_reg_i   (IssueReg),
        .retire_en_i   (write_en),
        .retire_reg_i  (WriteRegIn),
        .busy_o        (busy),
        .retire_last_o (retire_last),
        .sb_full_o     (sb_full),
        .sb_err_o      (sb_err)
    );

    // Without bypass, Busy holds through the retiring cycle and data appears next cycle.
    always_comb begin
        ReadData1 = regs_q[ReadReg1];
        ReadData2 = regs_q[ReadReg2];
        if (BYPASS_EN && write_en && (WriteRegIn == ReadReg1)) ReadData1 = WriteDataIn;
        if (BYPASS_EN && write_en && (WriteRegIn == ReadReg2)) ReadData2 = WriteDataIn;
        Busy1 = busy[ReadReg1] && !(BYPASS_EN && retire_last[ReadReg1]);
        Busy2 = busy[ReadReg2] && !(BYPASS_EN && retire_last[ReadReg2]);
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed-vector bench for reg_file_sb; expectations follow REG_FILE_BYPASS_EN when defined.
module tb_reg_file_sb;
    import reg_file_sb_pkg::*;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic      clk, rst_n;
    reg_idx_t  WriteRegIn, ReadReg1, ReadReg2, IssueReg;
    reg_data_t WriteDataIn, ReadData1, ReadData2;
    logic      write_en, issue_en, Busy1, Busy2, sb_full, sb_err;

    int n_vec = 0;
    int n_err = 0;

    reg_file_sb dut (
        .clk(clk), .rst_n(rst_n),
        .WriteRegIn(WriteRegIn), .WriteDataIn(WriteDataIn), .write_en(write_en),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .Busy1(Busy1), .Busy2(Busy2),
        .issue_en(issue_en), .IssueReg(IssueReg),
        .sb_full(sb_full), .sb_err(sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        write_en = 1'b0; issue_en = 1'b0;
        WriteRegIn = '0; WriteDataIn = '0; IssueReg = '0;
        ReadReg1 = '0; ReadReg2 = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        // 1. reset with random inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            WriteRegIn = reg_idx_t'($urandom); WriteDataIn = $urandom;
            write_en = 1'($urandom); issue_en = 1'($urandom);
            IssueReg = reg_idx_t'($urandom);
            ReadReg1 = reg_idx_t'($urandom); ReadReg2 = reg_idx_t'($urandom);
        end
        write_en = 1'b0;
        #1;
        chk("rst_rd1", ReadData1, 32'h0);
        chk("rst_rd2", ReadData2, 32'h0);
        chk("rst_busy", {30'b0, Busy1, Busy2}, 32'h0);
        chk("rst_full_err", {30'b0, sb_full, sb_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        step();
        WriteRegIn = 3'd5; WriteDataIn = 32'hDEADBEEF; write_en = 1'b1;
        step();
        write_en = 1'b0; ReadReg1 = 3'd5;
        #1;
        chk("r5_read", ReadData1, 32'hDEADBEEF);
        chk("r5_underflow_err", {31'b0, sb_err}, 32'h1);

        // 2. RAW stall on r3
        do_reset();
        issue_en = 1'b1; IssueReg = 3'd3; ReadReg1 = 3'd3;
        #1;
        chk("raw_busy_pre_issue", {31'b0, Busy1}, 32'h0);
        step();
        issue_en = 1'b0;
        #1;
        chk("raw_busy", {31'b0, Busy1}, 32'h1);
        write_en = 1'b1; WriteRegIn = 3'd3; WriteDataIn = 32'h12345678;
        #1;
        chk("raw_busy_retire_cyc", {31'b0, Busy1}, BYP ? 32'h0 : 32'h1);
        chk("raw_data_retire_cyc", ReadData1, BYP ? 32'h12345678 : 32'h0);
        step();
        write_en = 1'b0;
        #1;
        chk("raw_busy_after", {31'b0, Busy1}, 32'h0);
        chk("raw_data_after", ReadData1, 32'h12345678);
        chk("raw_err", {31'b0, sb_err}, 32'h0);

        // 3. saturation on r2
        do_reset();
        issue_en = 1'b1; IssueReg = 3'd2; ReadReg2 = 3'd2;
        #1;
        chk("sat_full_0", {31'b0, sb_full}, 32'h0);
        step(); step(); step();
        chk("sat_full_3", {31'b0, sb_full}, 32'h1);
        chk("sat_err_before", {31'b0, sb_err}, 32'h0);
        step();
        issue_en = 1'b0;
        #1;
        chk("sat_err_overflow", {31'b0, sb_err}, 32'h1);
        chk("sat_full_kept", {31'b0, sb_full}, 32'h1);
        write_en = 1'b1; WriteRegIn = 3'd2; WriteDataIn = 32'h2;
        step(); step();
        #1;
        chk("sat_busy_cnt1", {31'b0, Busy2}, BYP ? 32'h0 : 32'h1);
        step();
        write_en = 1'b0;
        #1;
        chk("sat_busy_drained", {31'b0, Busy2}, 32'h0);
        chk("sat_full_drained", {31'b0, sb_full}, 32'h0);
        chk("sat_err_sticky", {31'b0, sb_err}, 32'h1);

        // 4. simultaneous issue + retire on r1
        do_reset();
        issue_en = 1'b1; IssueReg = 3'd1; ReadReg1 = 3'd1;
        step();
        write_en = 1'b1; WriteRegIn = 3'd1; WriteDataIn = 32'hA5A50001;
        step();
        issue_en = 1'b0; write_en = 1'b0;
        #1;
        chk("sim_busy", {31'b0, Busy1}, 32'h1);
        chk("sim_err", {31'b0, sb_err}, 32'h0);
        chk("sim_data", ReadData1, 32'hA5A50001);
        write_en = 1'b1; WriteDataIn = 32'hA5A50002;
        step();
        write_en = 1'b0;
        #1;
        chk("sim_cnt_was_1", {31'b0, Busy1}, 32'h0);
        chk("sim_err_after", {31'b0, sb_err}, 32'h0);

        // 5. underflow on r7
        do_reset();
        ReadReg2 = 3'd7; IssueReg = 3'd7;
        write_en = 1'b1; WriteRegIn = 3'd7; WriteDataIn = 32'hCAFEF00D;
        step();
        write_en = 1'b0;
        #1;
        chk("uf_data", ReadData2, 32'hCAFEF00D);
        chk("uf_busy", {31'b0, Busy2}, 32'h0);
        chk("uf_full", {31'b0, sb_full}, 32'h0);
        chk("uf_err", {31'b0, sb_err}, 32'h1);

        // 6. async reset mid-operation
        do_reset();
        issue_en = 1'b1;
        for (int r = 0; r < 4; r++) begin
            IssueReg = reg_idx_t'(r);
            step();
        end
        issue_en = 1'b0; IssueReg = 3'd3;
        write_en = 1'b1; WriteRegIn = 3'd4; WriteDataIn = 32'h00000055;
        step();
        write_en = 1'b0; ReadReg1 = 3'd0; ReadReg2 = 3'd4;
        #1;
        chk("ar_busy_pre", {31'b0, Busy1}, 32'h1);
        chk("ar_data_pre", ReadData2, 32'h00000055);
        chk("ar_err_pre", {31'b0, sb_err}, 32'h1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_busy", {31'b0, Busy1}, 32'h0);
        chk("ar_data", ReadData2, 32'h0);
        chk("ar_full_err", {30'b0, sb_full, sb_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
